channel_injector: RTL and testbench

Channel-impairment stage between the convolutional encoder and the Viterbi decoder in the tx/rx loop. It takes each valid 2-bit encoder symbol and registers it through. On selected symbols it XORs in a programmable error mask, using a periodic-burst or LFSR-random pattern, inside a bounded measurement window. It also keeps symbol, errored-symbol and flipped-bit counts for BER analysis against decoder output.

---
 rtl/channel_pkg.sv | 24 ++
 rtl/channel_lfsr.sv | 28 ++
 rtl/channel_injector.sv | 118 +++++++++++
 tb/tb_channel_injector.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/channel_pkg.sv
// Shared types and constants for the channel impairment stage.
// Mode and state encodings, LFSR taps and a 2-bit popcount helper.
package channel_pkg;

  typedef enum logic [1:0] {
    MODE_CLEAN  = 2'b00,
    MODE_BURST  = 2'b01,
    MODE_RANDOM = 2'b10
  } mode_t;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    ACTIVE = 2'b01,
    DONE   = 2'b10
  } state_t;

  // x^16 + x^14 + x^13 + x^11 + 1, right-shifting Galois form
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  function automatic logic [1:0] popcount2(input logic [1:0] v);
    return {1'b0, v[1]} + {1'b0, v[0]};
  endfunction

endpackage

// File: rtl/channel_lfsr.sv
// 16-bit Galois LFSR that steps once per asserted adv_i.
// state_o is the current value, before the step taken on this edge.
module channel_lfsr
  import channel_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        adv_i,
  output logic [15:0] state_o
);

  logic [15:0] lfsr_q, lfsr_d;

  always_comb begin
    lfsr_d = lfsr_q;
    if (adv_i) lfsr_d = (lfsr_q >> 1) ^ (lfsr_q[0] ? LFSR_TAPS : 16'h0000);
  end

  always_ff @(posedge clk) begin
    if (rst) lfsr_q <= SEED;
    else     lfsr_q <= lfsr_d;
  end

  assign state_o = lfsr_q;

endmodule

// File: rtl/channel_injector.sv
// Registers encoder symbols through to the decoder, XOR-ing an error mask onto
// selected symbols inside a measurement window and keeping BER counters.
//
// state  | meaning
// IDLE   | after reset, no symbol accepted yet
// ACTIVE | inside the measurement window, injection allowed
// DONE   | window complete, symbols pass clean, error counters frozen
module channel_injector
  import channel_pkg::*;
#(
  parameter int          PERIOD_LOG2 = 5,
  parameter int          BURST_LEN   = 2,
  parameter int          WINDOW      = 256,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable_i,
  input  logic [1:0]  sym_i,
  input  logic [1:0]  mode_i,
  input  logic [1:0]  err_mask_i,
  output logic        valid_o,
  output logic [1:0]  sym_o,
  output logic        inj_o,
  output logic [15:0] sym_ct_o,
  output logic [15:0] err_sym_ct_o,
  output logic [15:0] bad_bit_ct_o,
  output logic        window_done_o
);

  localparam int          PERIOD      = 1 << PERIOD_LOG2;
  localparam logic [15:0] PHASE_MASK  = 16'(PERIOD - 1);
  localparam logic [15:0] BURST_START = 16'(PERIOD - BURST_LEN);
  localparam logic [15:0] LAST_K      = 16'(WINDOW - 1);
  localparam logic [15:0] CT_MAX      = 16'hFFFF;

  state_t      state_q, state_d;
  logic        valid_q;
  logic [1:0]  sym_q, sym_d;
  logic        inj_q, inj_d;
  logic [15:0] sym_ct_q, sym_ct_d;
  logic [15:0] err_ct_q, err_ct_d;
  logic [15:0] bad_ct_q, bad_ct_d;
  logic [15:0] lfsr;
  logic        sel;
  logic [16:0] bad_sum;

  channel_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
    .clk     (clk),
    .rst     (rst),
    .adv_i   (enable_i),
    .state_o (lfsr)
  );

  // k is sym_ct_q; the LFSR value used is the one before this symbol's step
  always_comb begin
    sel = 1'b0;
    case (mode_i)
      MODE_BURST:  sel = (sym_ct_q & PHASE_MASK) >= BURST_START;
      MODE_RANDOM: sel = (lfsr & PHASE_MASK) == 16'h0000;
      default:     sel = 1'b0;
    endcase
    if (state_q == DONE) sel = 1'b0;
  end

  always_comb begin
    state_d  = state_q;
    sym_d    = sym_q;
    inj_d    = inj_q;
    sym_ct_d = sym_ct_q;
    err_ct_d = err_ct_q;
    bad_ct_d = bad_ct_q;
    bad_sum  = {1'b0, bad_ct_q} + {15'b0, popcount2(err_mask_i)};
    if (enable_i) begin
      sym_d = sel ? (sym_i ^ err_mask_i) : sym_i;
      inj_d = sel && (err_mask_i != 2'b00);
      if (sym_ct_q != CT_MAX) sym_ct_d = sym_ct_q + 16'd1;
      if (inj_d) begin
        if (err_ct_q != CT_MAX) err_ct_d = err_ct_q + 16'd1;
        bad_ct_d = bad_sum[16] ? CT_MAX : bad_sum[15:0];
      end
      case (state_q)
        IDLE:    state_d = (sym_ct_q == LAST_K) ? DONE : ACTIVE;
        ACTIVE:  if (sym_ct_q == LAST_K) state_d = DONE;
        default: state_d = state_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      valid_q  <= 1'b0;
      sym_q    <= 2'b00;
      inj_q    <= 1'b0;
      sym_ct_q <= 16'h0000;
      err_ct_q <= 16'h0000;
      bad_ct_q <= 16'h0000;
    end else begin
      state_q  <= state_d;
      valid_q  <= enable_i;
      sym_q    <= sym_d;
      inj_q    <= inj_d;
      sym_ct_q <= sym_ct_d;
      err_ct_q <= err_ct_d;
      bad_ct_q <= bad_ct_d;
    end
  end

  assign valid_o       = valid_q;
  assign sym_o         = sym_q;
  assign inj_o         = inj_q;
  assign sym_ct_o      = sym_ct_q;
  assign err_sym_ct_o  = err_ct_q;
  assign bad_bit_ct_o  = bad_ct_q;
  assign window_done_o = (state_q == DONE);

endmodule

// File: tb/tb_channel_injector.sv
// Randomized bench for channel_injector; expected behaviour comes from a
// symbol-level model (window index, period phase, LFSR sequence).
module tb_channel_injector;

  localparam int WINDOW      = 256;
  localparam int PERIOD      = 32;
  localparam int BURST_LEN   = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable_i;
  logic [1:0]  sym_i, mode_i, err_mask_i;
  logic        valid_o, inj_o, window_done_o;
  logic [1:0]  sym_o;
  logic [15:0] sym_ct_o, err_sym_ct_o, bad_bit_ct_o;

  channel_injector dut (
    .clk           (clk),
    .rst           (rst),
    .enable_i      (enable_i),
    .sym_i         (sym_i),
    .mode_i        (mode_i),
    .err_mask_i    (err_mask_i),
    .valid_o       (valid_o),
    .sym_o         (sym_o),
    .inj_o         (inj_o),
    .sym_ct_o      (sym_ct_o),
    .err_sym_ct_o  (err_sym_ct_o),
    .bad_bit_ct_o  (bad_bit_ct_o),
    .window_done_o (window_done_o)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // reference model state
  int          m_cnt, m_err, m_bad;
  logic [15:0] m_lfsr;
  logic        exp_valid, exp_inj;
  logic [1:0]  exp_sym;

  function automatic logic [52:0] dut_snap();
    return {valid_o, sym_o, inj_o, sym_ct_o, err_sym_ct_o, bad_bit_ct_o, window_done_o};
  endfunction

  function automatic logic [52:0] model_snap();
    return {exp_valid, exp_sym, exp_inj, 16'(m_cnt), 16'(m_err), 16'(m_bad),
            (m_cnt >= WINDOW) ? 1'b1 : 1'b0};
  endfunction

  task automatic model_reset();
    m_cnt = 0; m_err = 0; m_bad = 0; m_lfsr = 16'hACE1;
    exp_valid = 1'b0; exp_sym = 2'b00; exp_inj = 1'b0;
  endtask

  task automatic model_edge(input bit en, input bit [1:0] s, input bit [1:0] md, input bit [1:0] mk);
    bit sel;
    if (!en) begin
      exp_valid = 1'b0;
      return;
    end
    sel = 1'b0;
    if (m_cnt < WINDOW) begin
      if (md == 2'd1)      sel = (m_cnt % PERIOD) >= (PERIOD - BURST_LEN);
      else if (md == 2'd2) sel = (int'(m_lfsr) % PERIOD) == 0;
    end
    exp_valid = 1'b1;
    exp_sym   = sel ? (s ^ mk) : s;
    exp_inj   = sel && (mk != 2'b00);
    if (exp_inj) begin
      m_err = (m_err < 65535) ? m_err + 1 : 65535;
      m_bad = m_bad + $countones(mk);
      if (m_bad > 65535) m_bad = 65535;
    end
    m_cnt = (m_cnt < 65535) ? m_cnt + 1 : 65535;
    if (m_lfsr[0]) m_lfsr = (m_lfsr >> 1) ^ 16'hB400;
    else           m_lfsr = m_lfsr >> 1;
  endtask

  task automatic cycle(input bit en, input bit [1:0] s, input bit [1:0] md, input bit [1:0] mk);
    enable_i = en; sym_i = s; mode_i = md; err_mask_i = mk;
    @(posedge clk);
    #1;
    model_edge(en, s, md, mk);
  endtask

  task automatic do_reset(input bit en);
    rst = 1'b1; enable_i = en; sym_i = 2'($urandom); mode_i = 2'd1; err_mask_i = 2'b11;
    @(posedge clk);
    #1;
    rst = 1'b0; enable_i = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    do_reset(1'b1);
    if (valid_o !== 1'b0) begin n_errors++; $display("FAIL reset_valid got %b want 0", valid_o); end
    n_checks++;
    if (sym_o !== 2'b00) begin n_errors++; $display("FAIL reset_sym got %b want 00", sym_o); end
    n_checks++;
    if (inj_o !== 1'b0) begin n_errors++; $display("FAIL reset_inj got %b want 0", inj_o); end
    n_checks++;
    if ({sym_ct_o, err_sym_ct_o, bad_bit_ct_o} !== 48'h0) begin
      n_errors++;
      $display("FAIL reset_counters got %h/%h/%h want 0/0/0", sym_ct_o, err_sym_ct_o, bad_bit_ct_o);
    end
    n_checks++;
    if (window_done_o !== 1'b0) begin n_errors++; $display("FAIL reset_done got %b want 0", window_done_o); end
    n_checks++;
  endtask

  task automatic test_clean();
    do_reset(1'b0);
    for (int i = 0; i < 300; i++) begin
      cycle(1'b1, 2'(i % 4), (i % 3 == 0) ? 2'd3 : 2'd0, 2'($urandom));
      if (dut_snap() !== model_snap()) begin
        n_errors++;
        $display("FAIL clean k=%0d dut=%h model=%h", i, dut_snap(), model_snap());
      end
      n_checks++;
      if ((i == 254 || i == 255) && window_done_o !== (i == 255)) begin
        n_errors++;
        $display("FAIL clean_done_edge k=%0d got %b want %b", i, window_done_o, i == 255);
      end
      if (i == 254 || i == 255) n_checks++;
    end
    if (sym_ct_o !== 16'd300 || err_sym_ct_o !== 16'd0) begin
      n_errors++;
      $display("FAIL clean_end sym_ct=%0d err=%0d want 300/0", sym_ct_o, err_sym_ct_o);
    end
    n_checks++;
  endtask

  task automatic test_burst_full();
    do_reset(1'b0);
    for (int i = 0; i < 300; i++) begin
      cycle(1'b1, 2'($urandom), 2'd1, 2'b11);
      if (dut_snap() !== model_snap()) begin
        n_errors++;
        $display("FAIL burst_full k=%0d dut=%h model=%h", i, dut_snap(), model_snap());
      end
      n_checks++;
    end
    if (err_sym_ct_o !== 16'd16 || bad_bit_ct_o !== 16'd32) begin
      n_errors++;
      $display("FAIL burst_full_end err=%0d bad=%0d want 16/32", err_sym_ct_o, bad_bit_ct_o);
    end
    n_checks++;
  endtask

  task automatic test_burst_gapped();
    do_reset(1'b0);
    for (int i = 0; i < 520; i++) begin
      cycle(i % 2 == 0, 2'($urandom), 2'd1, 2'b01);
      if (dut_snap() !== model_snap()) begin
        n_errors++;
        $display("FAIL burst_gapped cyc=%0d dut=%h model=%h", i, dut_snap(), model_snap());
      end
      n_checks++;
    end
    if (err_sym_ct_o !== 16'd16 || bad_bit_ct_o !== 16'd16) begin
      n_errors++;
      $display("FAIL burst_gapped_end err=%0d bad=%0d want 16/16", err_sym_ct_o, bad_bit_ct_o);
    end
    n_checks++;
  endtask

  task automatic test_random();
    do_reset(1'b0);
    for (int i = 0; i < 256; i++) begin
      cycle(1'b1, 2'($urandom), 2'd2, 2'b10);
      if (dut_snap() !== model_snap()) begin
        n_errors++;
        $display("FAIL random k=%0d dut=%h model=%h", i, dut_snap(), model_snap());
      end
      n_checks++;
    end
    if (window_done_o !== 1'b1 || err_sym_ct_o !== 16'(m_err)) begin
      n_errors++;
      $display("FAIL random_end done=%b err=%0d want 1/%0d", window_done_o, err_sym_ct_o, m_err);
    end
    n_checks++;
  endtask

  task automatic test_zero_mask();
    do_reset(1'b0);
    for (int i = 0; i < 256; i++) begin
      sym_i = 2'($urandom);
      cycle(1'b1, sym_i, 2'd2, 2'b00);
      if (inj_o !== 1'b0 || sym_o !== sym_i) begin
        n_errors++;
        $display("FAIL zero_mask k=%0d got inj=%b sym=%b want 0/%b", i, inj_o, sym_o, sym_i);
      end
      n_checks++;
    end
    if (bad_bit_ct_o !== 16'd0 || err_sym_ct_o !== 16'd0) begin
      n_errors++;
      $display("FAIL zero_mask_end bad=%0d err=%0d want 0/0", bad_bit_ct_o, err_sym_ct_o);
    end
    n_checks++;
  endtask

  task automatic test_reset_mid();
    do_reset(1'b0);
    for (int i = 0; i < 100; i++) cycle(1'b1, 2'($urandom), 2'd1, 2'b11);
    do_reset(1'b1);
    if (dut_snap() !== 53'h0) begin
      n_errors++;
      $display("FAIL reset_mid_zero got %h want 0", dut_snap());
    end
    n_checks++;
    for (int i = 0; i < 256; i++) begin
      cycle(1'b1, 2'($urandom), 2'd1, 2'b11);
      if (dut_snap() !== model_snap()) begin
        n_errors++;
        $display("FAIL reset_mid k=%0d dut=%h model=%h", i, dut_snap(), model_snap());
      end
      n_checks++;
    end
    if (err_sym_ct_o !== 16'd16 || bad_bit_ct_o !== 16'd32 || window_done_o !== 1'b1) begin
      n_errors++;
      $display("FAIL reset_mid_end err=%0d bad=%0d done=%b want 16/32/1",
               err_sym_ct_o, bad_bit_ct_o, window_done_o);
    end
    n_checks++;
  endtask

  task automatic test_mixed();
    do_reset(1'b0);
    for (int i = 0; i < 600; i++) begin
      cycle($urandom_range(0, 3) != 0, 2'($urandom), 2'($urandom), 2'($urandom));
      if (dut_snap() !== model_snap()) begin
        n_errors++;
        $display("FAIL mixed cyc=%0d dut=%h model=%h", i, dut_snap(), model_snap());
      end
      n_checks++;
    end
  endtask

  initial begin
    rst = 1'b1; enable_i = 1'b0; sym_i = 2'b00; mode_i = 2'b00; err_mask_i = 2'b00;
    model_reset();
    test_reset();
    test_clean();
    test_burst_full();
    test_burst_gapped();
    test_random();
    test_zero_mask();
    test_reset_mid();
    test_mixed();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
